mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 start  input  1  one-cycle pulse; begins a load when IDLE, ignored otherwise.
REQ-004 baseAddr  input  10  byte address of first word; bits[1:0] treated as 00.
REQ-005 wordCount  input  9  number of 32-bit words to load; latched on start; values >256 treated as 256.
REQ-006 wordIn  input  32  incoming program/data word.
REQ-007 wordValid  input  1  wordIn is valid this cycle.
REQ-008 wordReady  output  1  loader accepts wordIn this cycle.
REQ-009 regWE  output  1  memory write enable; memory writes DataIn to DataAddr on rising clk when 1.
REQ-010 DataAddr  output  10  memory byte address.
REQ-011 DataIn  output  32  memory write data.
REQ-012 DataOut  input  32  memory read data, combinational from DataAddr.
REQ-013 busy  output  1  high in LOAD and VERIFY.
REQ-014 done  output  1  one-cycle pulse at end of operation.
REQ-015 error  output  1  readback checksum mismatch; sticky until next accepted start.
REQ-016 checksum  output  32  modulo-2^32 sum of all accepted words; held from DONE until next accepted start.

Function
REQ-017 States SHALL be IDLE, LOAD, VERIFY, DONE.
REQ-018 IDLE: start=1 SHALL latch ptr=baseAddr&~3, remaining=clamped wordCount, clear sum/readSum/error; go LOAD if count>0, else DONE.
REQ-019 LOAD: wordReady=1; regWE=wordValid; DataIn=wordIn; DataAddr=ptr (zero-cycle pass-through).
REQ-020 Transfer SHALL occur on an edge where wordValid&&wordReady; memory write happens on that same edge.
REQ-021 On each transfer: ptr+=4 modulo 1024 (0x3FC wraps to 0x000), sum+=wordIn modulo 2^32, remaining-=1.
REQ-022 wordValid low in LOAD SHALL stall with no write and no pointer/sum change.
REQ-023 Transfer of the last word SHALL move to VERIFY with ptr reloaded to the latched base and remaining reloaded to the latched count.
REQ-024 VERIFY: regWE=0, wordReady=0, DataAddr=ptr; every cycle readSum+=DataOut, ptr+=4 (same wrap), remaining-=1; lasts exactly count cycles.
REQ-025 After the last VERIFY cycle go DONE; error SHALL be set iff final readSum != sum.
REQ-026 DONE: done=1 for exactly one cycle, busy=0, checksum=sum; next state IDLE.
REQ-027 Outside LOAD, regWE and wordReady SHALL be 0; in IDLE/DONE DataAddr SHALL hold last ptr.
REQ-028 start asserted in LOAD/VERIFY/DONE SHALL be ignored with no effect.
REQ-029 Start-to-done latency with continuous wordValid SHALL be 2*N+1 cycles for N>0, and 1 cycle for N=0.

Reset
REQ-030 reset_n=0 at a rising edge SHALL force IDLE, ptr=0, DataAddr=0, sum=readSum=0, checksum=0, error=0, done=0, busy=0.
REQ-031 regWE and wordReady SHALL be 0 combinationally whenever reset_n=0, including mid-LOAD, so no write occurs on the reset edge.
REQ-032 After reset release, the first accepted start SHALL behave identically to a start from power-up.

Verification
REQ-033 Base 0x000, count 2, words 0x201d3ffc then 0x2008000e with continuous valid -> writes at 0x000 and 0x004 on consecutive edges, 2 VERIFY cycles, done 5 cycles after start, checksum 0x4025400a, error 0; memory reads back both words.
REQ-034 Base 0x100, count 2, wordValid pattern 1,0,0,1 -> regWE high only in cycles 1 and 4, writes at 0x100 and 0x104, no write on stall cycles.
REQ-035 Base 0x3FC, count 2 -> writes at 0x3FC then 0x000, VERIFY reads 0x3FC then 0x000, error 0.
REQ-036 Count 0 -> done pulse 1 cycle after start, regWE never high, checksum 0, error 0.
REQ-037 Memory model corrupts readback at 0x004 -> error=1 at DONE, held through IDLE, cleared by next accepted start.
REQ-038 reset_n low for one cycle mid-LOAD -> no write that cycle, next cycle IDLE, busy 0, checksum 0; following start loads normally.

Source files
------------

// File: rtl/mem_loader.sv
// Loads a block of words into a byte-addressed memory, then reads the block back
// and compares its checksum against the sum of the words that were written.
module mem_loader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [9:0]  baseAddr,
  input  logic [8:0]  wordCount,
  input  logic [31:0] wordIn,
  input  logic        wordValid,
  output logic        wordReady,
  output logic        regWE,
  output logic [9:0]  DataAddr,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} loaderState_t;

  loaderState_t state;
  logic [9:0]   ptr;
  logic [9:0]   baseLatch;
  logic [9:0]   alignedBase;
  logic [8:0]   remaining;
  logic [8:0]   countLatch;
  logic [8:0]   clampedCount;
  logic [31:0]  sum;
  logic [31:0]  readSum;
  logic [31:0]  readSumNext;

  assign alignedBase  = baseAddr & 10'h3FC;
  assign clampedCount = (wordCount > 9'd256) ? 9'd256 : wordCount;

  // Handshake is gated by reset_n so a reset edge during LOAD never writes memory.
  assign wordReady   = reset_n && (state == LOAD);
  assign regWE       = wordReady && wordValid;
  assign DataAddr    = ptr;
  assign DataIn      = wordIn;
  assign readSumNext = readSum + DataOut;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      baseLatch  <= '0;
      remaining  <= '0;
      countLatch <= '0;
      sum        <= '0;
      readSum    <= '0;
      checksum   <= '0;
      error      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr        <= alignedBase;
            baseLatch  <= alignedBase;
            remaining  <= clampedCount;
            countLatch <= clampedCount;
            sum        <= '0;
            readSum    <= '0;
            checksum   <= '0;
            error      <= 1'b0;
            if (clampedCount != 9'd0) begin
              state <= LOAD;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (regWE) begin
            sum <= sum + wordIn;
            // Last word rewinds the pointer so the readback walks the same block.
            if (remaining == 9'd1) begin
              state     <= VERIFY;
              ptr       <= baseLatch;
              remaining <= countLatch;
            end else begin
              ptr       <= ptr + 10'd4;
              remaining <= remaining - 9'd1;
            end
          end
        end
        VERIFY: begin
          readSum   <= readSumNext;
          ptr       <= ptr + 10'd4;
          remaining <= remaining - 9'd1;
          if (remaining == 9'd1) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            checksum <= sum;
            error    <= (readSumNext != sum);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a behavioural memory and scoreboards for
// expected memory writes and expected readback addresses.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  baseAddr;
  logic [8:0]  wordCount;
  logic [31:0] wordIn;
  logic        wordValid;
  logic        wordReady;
  logic        regWE;
  logic [9:0]  DataAddr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  logic [31:0] mem [256];
  logic [31:0] words [256];
  logic        corrupt = 1'b0;
  logic [41:0] writeQ[$];
  logic [9:0]  readQ[$];
  int          compared = 0;
  int          mismatched = 0;

  mem_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .baseAddr(baseAddr),
    .wordCount(wordCount), .wordIn(wordIn), .wordValid(wordValid),
    .wordReady(wordReady), .regWE(regWE), .DataAddr(DataAddr), .DataIn(DataIn),
    .DataOut(DataOut), .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Memory model; corrupt flips bit 0 of the word read back from 0x004.
  always @(posedge clk) if (regWE) mem[DataAddr[9:2]] <= DataIn;
  assign DataOut = mem[DataAddr[9:2]] ^ ((corrupt && DataAddr == 10'h004) ? 32'h1 : 32'h0);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Every write and every readback address is matched against the scoreboards.
  always @(negedge clk) begin
    logic [41:0] expW;
    logic [9:0]  expR;
    if (regWE) begin
      expW = (writeQ.size() > 0) ? writeQ.pop_front() : 'x;
      checkOutput("write", {22'd0, DataAddr, DataIn}, {22'd0, expW});
    end
    if (reset_n && busy && !wordReady) begin
      expR = (readQ.size() > 0) ? readQ.pop_front() : 'x;
      checkOutput("verifyAddr", {54'd0, DataAddr}, {54'd0, expR});
    end
  end

  task automatic applyStimulus(input logic [9:0] base, input int n, input logic [15:0] pat,
                               input bit pokeStart, input logic expErr, input int expLat);
    int          eff;
    int          cycles;
    int          idx;
    int          pc;
    logic [9:0]  a;
    logic [31:0] expSum;
    eff    = (n > 256) ? 256 : n;
    expSum = 0;
    a      = base & 10'h3FC;
    for (int i = 0; i < eff; i++) begin
      writeQ.push_back({a, words[i]});
      readQ.push_back(a);
      expSum += words[i];
      a += 10'd4;
    end
    @(posedge clk); #1;
    start = 1'b1; baseAddr = base; wordCount = n[8:0];
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1; idx = 0; pc = 0;
    checkOutput("errorClearedOnStart", {63'd0, error}, 64'd0);
    while (!done && cycles < 2000) begin
      wordValid = 1'b0;
      if (wordReady) begin
        wordValid = (pc < 16) ? pat[pc] : 1'b1;
        wordIn    = words[idx];
        start     = pokeStart && (pc == 0);
        baseAddr  = 10'h200;
        wordCount = 9'd5;
        pc++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (wordValid) idx++;
      cycles++;
    end
    wordValid = 1'b0;
    checkOutput("latency", 64'(cycles), 64'(expLat));
    checkOutput("doneBusy", {62'd0, done, busy}, 64'b10);
    checkOutput("checksum", {32'd0, checksum}, {32'd0, expSum});
    checkOutput("errorAtDone", {63'd0, error}, {63'd0, expErr});
    @(posedge clk); #1;
    checkOutput("donePulseOne", {63'd0, done}, 64'd0);
    checkOutput("errorHeld", {63'd0, error}, {63'd0, expErr});
    checkOutput("queuesDrained", 64'(writeQ.size() + readQ.size()), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; baseAddr = '0; wordCount = '0;
    wordIn = '0; wordValid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetOutputs", {42'd0, busy, done, error, regWE, wordReady, DataAddr, 7'd0},
                64'd0);
    checkOutput("resetChecksum", {32'd0, checksum}, 64'd0);
    reset_n = 1'b1;

    $display("[TB] basic load of two words");
    words[0] = 32'h201d3ffc; words[1] = 32'h2008000e;
    applyStimulus(10'h000, 2, 16'hFFFF, 1'b0, 1'b0, 5);
    checkOutput("checksumConst", {32'd0, checksum}, 64'h4025400a);
    checkOutput("mem0", {32'd0, mem[0]}, 64'h201d3ffc);
    checkOutput("mem1", {32'd0, mem[1]}, 64'h2008000e);

    $display("[TB] stalled load at 0x100");
    words[0] = 32'hA5A5_0001; words[1] = 32'h5A5A_0002;
    applyStimulus(10'h100, 2, 16'b1001, 1'b0, 1'b0, 7);

    $display("[TB] address wrap at 0x3FC");
    words[0] = 32'h1111_2222; words[1] = 32'h3333_4444;
    applyStimulus(10'h3FC, 2, 16'hFFFF, 1'b0, 1'b0, 5);

    $display("[TB] zero-length load");
    applyStimulus(10'h080, 0, 16'hFFFF, 1'b0, 1'b0, 1);

    $display("[TB] corrupted readback");
    words[0] = 32'hCAFE_0000; words[1] = 32'h0BAD_F00D;
    corrupt = 1'b1;
    applyStimulus(10'h000, 2, 16'hFFFF, 1'b0, 1'b1, 5);
    corrupt = 1'b0;

    $display("[TB] start ignored mid-load");
    words[2] = 32'h7777_8888;
    applyStimulus(10'h080, 3, 16'hFFFF, 1'b1, 1'b0, 7);

    $display("[TB] reset during load");
    words[0] = 32'hDEAD_0001; words[1] = 32'hDEAD_0002;
    @(posedge clk); #1;
    start = 1'b1; baseAddr = 10'h040; wordCount = 9'd4;
    writeQ.push_back({10'h040, words[0]});
    @(posedge clk); #1;
    start = 1'b0; wordValid = 1'b1; wordIn = words[0];
    @(posedge clk); #1;
    wordIn = words[1]; reset_n = 1'b0;
    #1;
    checkOutput("resetGatesWrite", {62'd0, regWE, wordReady}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; wordValid = 1'b0;
    checkOutput("afterReset", {43'd0, busy, done, error, DataAddr, 7'd0}, 64'd0);
    checkOutput("afterResetChecksum", {32'd0, checksum}, 64'd0);
    checkOutput("noWriteOnReset", {32'd0, mem[17]}, 64'd0);
    applyStimulus(10'h040, 2, 16'hFFFF, 1'b0, 1'b0, 5);

    $display("[TB] count above 256 clamps");
    for (int i = 0; i < 256; i++) words[i] = 32'h0101_0101 * i + 32'h1357;
    applyStimulus(10'h0C1, 300, 16'hFFFF, 1'b0, 1'b0, 513);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
